bus_wait_responder: RTL and testbench

- Downstream slave for the bus-control FSM: consumes its registered state code and produces the `ok` completion that releases that FSM from Delay.
- Contains a 2^ADDR_W x DATA_W register file and a programmable wait-state counter.
- Performs the write or read when the wait expires, and maintains a transfer counter and a sticky protocol-error flag.

---
 rtl/bus_wait_responder.sv | 114 +++++++++++
 tb/tb_bus_wait_responder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/bus_wait_responder.sv
// bus_wait_responder: wait-state slave that completes controller Read/Write transfers and raises ok
module bus_wait_responder #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int WAIT_W = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [2:0]        i_stat,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [WAIT_W-1:0] i_wait_cfg,
    output logic              o_ok,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid,
    output logic              o_busy,
    output logic              o_err,
    output logic [7:0]        o_xfer_cnt
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    localparam int DEPTH = 1 << ADDR_W;
    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                err_q, err_d;
    logic [7:0]          xfer_q, xfer_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic                st_rst, st_rd, st_wr, st_dly, st_idle;
    assign st_rst  = i_stat == 3'b000;
    assign st_rd   = i_stat == 3'b010;
    assign st_wr   = i_stat == 3'b011;
    assign st_dly  = i_stat == 3'b100;
    assign st_idle = !(st_rst || st_rd || st_wr || st_dly);
    // ok in Idle with Delay keeps an orphaned controller from deadlocking
    assign o_ok       = (state_q == S_WAIT) ? (cnt_q == '0) : st_dly;
    assign o_busy     = state_q == S_WAIT;
    assign o_rdata    = rdata_q;
    assign o_rvalid   = rvalid_q;
    assign o_err      = err_q;
    assign o_xfer_cnt = xfer_q;
    // next-state: request capture, wait countdown, completion, abort and error tracking
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = err_q;
        xfer_d   = xfer_q;
        mem_d    = mem_q;
        if (state_q == S_IDLE) begin
            if (st_rd || st_wr) begin
                state_d = S_WAIT;
                wr_d    = st_wr;
                addr_d  = i_addr;
                wdata_d = i_wdata;
                cnt_d   = i_wait_cfg;
            end else if (st_dly) begin
                err_d = 1'b1;
            end
        end else if (st_dly) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                state_d = S_IDLE;
                xfer_d  = xfer_q + 8'd1;
                if (wr_q) begin
                    mem_d[addr_q] = wdata_q;
                end else begin
                    rdata_d  = mem_q[addr_q];
                    rvalid_d = 1'b1;
                end
            end
        end else if (st_rd || st_wr) begin
            err_d = 1'b1;
        end else begin
            state_d = S_IDLE;
            err_d   = err_q | st_idle;
        end
    end
    // state and register-file flops; async reset discards any pending transfer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            xfer_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            xfer_q   <= xfer_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: tb/tb_bus_wait_responder.sv
// tb_bus_wait_responder: directed stimulus with a transaction-level model checked every cycle
module tb_bus_wait_responder;
    localparam logic [2:0] RST = 3'b000, IDL = 3'b001, RD = 3'b010, WR = 3'b011, DLY = 3'b100;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] stat = IDL;
    logic [3:0] addr = '0;
    logic [7:0] wdata = '0;
    logic [2:0] cfg = '0;
    logic       o_ok, o_rvalid, o_busy, o_err;
    logic [7:0] o_rdata, o_xfer_cnt;
    int total = 0, bad = 0;
    bit en = 1'b0;
    int low;

    bus_wait_responder dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stat(stat), .i_addr(addr), .i_wdata(wdata),
        .i_wait_cfg(cfg), .o_ok(o_ok), .o_rdata(o_rdata), .o_rvalid(o_rvalid),
        .o_busy(o_busy), .o_err(o_err), .o_xfer_cnt(o_xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: a request opens a transfer of N+1 Delay cycles; the last one completes it
    bit         m_pend, m_wr, m_rvalid, m_err;
    int         m_k, m_n;
    logic [3:0] m_a;
    logic [7:0] m_d, m_rdata, m_cnt;
    logic [7:0] m_mem [16];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 0; m_wr <= 0; m_k <= 0; m_n <= 0; m_a <= '0; m_d <= '0;
            m_err <= 0; m_cnt <= '0; m_rdata <= '0; m_rvalid <= 0;
            for (int i = 0; i < 16; i++) m_mem[i] <= '0;
        end else begin
            m_rvalid <= 0;
            if (!m_pend) begin
                if (stat == RD || stat == WR) begin
                    m_pend <= 1; m_wr <= (stat == WR); m_a <= addr; m_d <= wdata;
                    m_n <= int'(cfg); m_k <= 0;
                end else if (stat == DLY) m_err <= 1;
            end else if (stat == DLY) begin
                if (m_k == m_n) begin
                    m_pend <= 0;
                    m_cnt <= m_cnt + 8'd1;
                    if (m_wr) m_mem[m_a] <= m_d;
                    else begin m_rdata <= m_mem[m_a]; m_rvalid <= 1; end
                end else m_k <= m_k + 1;
            end else if (stat == RD || stat == WR) m_err <= 1;
            else begin
                m_pend <= 0;
                if (stat != RST) m_err <= 1;
            end
        end
    end

    always @(negedge clk) begin
        if (en) begin
            check("ok", o_ok, m_pend ? (m_k == m_n) : (stat == DLY));
            check("busy", o_busy, m_pend);
            check("err", o_err, m_err);
            check("xfer_cnt", o_xfer_cnt, m_cnt);
            check("rvalid", o_rvalid, m_rvalid);
            check("rdata", o_rdata, m_rdata);
        end
    end

    // Called at posedge+1 with the controller Idle; returns one cycle after the completing Delay
    task automatic xfer(input bit wr, input logic [3:0] a, input logic [7:0] d,
                        input logic [2:0] n, output int lo);
        bit got = 0;
        stat = wr ? WR : RD; addr = a; wdata = d; cfg = n;
        @(posedge clk); #1 stat = DLY;
        lo = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (o_ok) got = 1;
            else begin lo++; @(posedge clk); #1; end
        end
        if (!got) check("ok_timeout", 0, 1);
        @(posedge clk); #1 stat = IDL;
    endtask

    task automatic pulse_reset();
        rst_n = 0; stat = RST;
        @(posedge clk); #1 rst_n = 1; stat = IDL;
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 en = 1;
        check("rst_ok", o_ok, 0);
        check("rst_xfer", o_xfer_cnt, 0);
        rst_n = 1;
        @(posedge clk); #1;
        xfer(1, 4'd3, 8'hA5, 3'd0, low);
        check("w3_low_cycles", low, 0);
        check("w3_xfer_cnt", o_xfer_cnt, 1);
        xfer(0, 4'd3, 8'h00, 3'd5, low);
        check("r3_low_cycles", low, 5);
        check("r3_rvalid", o_rvalid, 1);
        check("r3_rdata", o_rdata, 8'hA5);
        @(posedge clk); #1;
        check("r3_rvalid_drop", o_rvalid, 0);
        xfer(0, 4'd7, 8'h00, 3'd2, low);
        check("r7_rdata", o_rdata, 8'h00);
        check("r7_err", o_err, 0);
        check("r7_low_cycles", low, 2);
        stat = WR; addr = 4'd2; wdata = 8'h3C; cfg = 3'd6;
        @(posedge clk); #1 stat = DLY;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 0; stat = RST;
        #2;
        check("arst_busy", o_busy, 0);
        check("arst_xfer", o_xfer_cnt, 0);
        check("arst_ok", o_ok, 0);
        @(posedge clk); #1 rst_n = 1; stat = IDL;
        @(posedge clk); #1;
        xfer(0, 4'd2, 8'h00, 3'd1, low);
        check("r2_after_rst", o_rdata, 8'h00);
        stat = DLY;
        #1 check("orphan_ok", o_ok, 1);
        @(posedge clk); #1;
        check("orphan_err", o_err, 1);
        check("orphan_xfer", o_xfer_cnt, 1);
        stat = IDL;
        @(posedge clk); #1;
        check("err_sticky", o_err, 1);
        pulse_reset();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] ib;
            ib = 8'(i);
            xfer(1, ib[3:0], ib ^ 8'h5A, 3'd0, low);
        end
        check("wrap_xfer", o_xfer_cnt, 0);
        xfer(0, 4'd15, 8'h00, 3'd1, low);
        check("wrap_readback", o_rdata, 8'hA5);
        check("wrap_err", o_err, 0);
        en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
